// File: rtl/seq_divider_32_if.sv
// Start/busy/done handshake between the EX-stage issue logic and the iterative divider.
// The issuer holds the master modport; the divider is the slave.
interface seq_divider_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_32.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU) for the EX stage.
// One trial subtract per cycle on operand magnitudes; signs are restored in FIX.

module subtractor_32_bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Diff,
  output logic        BorrowOut
);
  // BorrowOut is the carry of A + ~B + 1: 1 means A >= B (no borrow).
  assign {BorrowOut, Diff} = {1'b0, A} + {1'b0, ~B} + 33'd1;
endmodule

module seq_divider_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_divider_32_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_bout;
  logic             w_carry;
  logic             w_ge;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_a_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign w_b_neg = bus.is_signed & bus.divisor[WIDTH-1];
  // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
  assign w_a_mag = w_a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_b_mag = w_b_neg ? (~bus.divisor  + 1'b1) : bus.divisor;

  assign w_shifted = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_carry   = r_rem[WIDTH-1];

  subtractor_32_bit u_sub (
    .A         (w_shifted),
    .B         (r_b),
    .Diff      (w_diff),
    .BorrowOut (w_bout)
  );

  // The shifted-out bit makes the partial remainder 33 bits wide; if set it
  // always exceeds |b|.
  assign w_ge = w_carry | w_bout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_b     <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_zero  <= (bus.divisor == '0);
            // Divide-by-zero skips the iterations; r_q carries the raw
            // dividend through to the remainder output.
            if (bus.divisor == '0) begin
              r_q     <= bus.dividend;
              r_state <= S_FIX;
            end else begin
              r_q     <= w_a_mag;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff : w_shifted;
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_zero) begin
            r_quot <= '1;
            r_remo <= r_q;
            r_dbz  <= 1'b1;
          end else begin
            r_quot <= r_neg_q ? (~r_q   + 1'b1) : r_q;
            r_remo <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider_32.sv
// Randomized scoreboard bench for seq_divider_32: driver pushes expected results from
// a plain-arithmetic reference, a negedge monitor pops and compares on every done.
module tb_seq_divider_32;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   t0;

  seq_divider_32_if bus ();

  seq_divider_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          t;
    int          lat;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc counts rising edges; at a negedge it equals the number of the last edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sd;
    e.a = a; e.b = b; e.s = s; e.z = 1'b0; e.t = 0;
    e.lat = (b == 32'd0) ? 1 : 33;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.z = 1'b1;
    end else if (!s) begin
      e.q = a / b; e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0;
    end else begin
      sa = a; sd = b;
      e.q = 32'(sa / sd);
      e.r = 32'(sa % sd);
    end
    return e;
  endfunction

  // Called at a negedge; start is sampled on the next rising edge (T = cyc+1).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int   k;
    k = 0;
    while ((bus.busy || bus.done || !rst_n) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: busy=%0b done=%0b still set after %0d cycles", bus.busy, bus.done, k);
    end else begin
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
      e = model(a, b, s);
      e.t = cyc + 1;
      t0 = e.t;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = $urandom; bus.divisor = $urandom; bus.is_signed = 1'($urandom);
    end
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: one done pulse per accepted start, checked against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("quotient %h/%h s=%0b", e.a, e.b, e.s), bus.quotient, e.q);
        chk($sformatf("remainder %h/%h s=%0b", e.a, e.b, e.s), bus.remainder, e.r);
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
        chk("done_latency", 32'(cyc - e.t), 32'(e.lat));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int          k;
    n_vec = 0; n_err = 0; t0 = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_quotient", bus.quotient, 32'd0);
    chk("reset_remainder", bus.remainder, 32'd0);
    chk("reset_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: unsigned, signed, boundaries, divide-by-zero
    issue(32'd100, 32'd7, 1'b0);
    issue(-32'sd100, 32'd7, 1'b1);
    issue(32'd100, -32'sd7, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'h0000_1234, 32'd0, 1'b0);
    issue(32'hFFFF_1234, 32'd0, 1'b1);
    issue(32'd5, 32'd9, 1'b1);

    // Handshake: starts at T+5 and T+34 ignored, T+35 accepted
    issue(32'd1000, 32'd13, 1'b0);
    k = t0;
    wait_cyc(k + 4);
    pulse(32'd77, 32'd1, 1'b0);
    chk("busy_after_ignored_start", 32'(bus.busy), 32'd1);
    wait_cyc(k + 33);
    pulse(32'd55, 32'd5, 1'b1);
    issue(32'd4242, 32'd21, 1'b0);
    chk("fresh_start_at_T35", 32'(t0 - k), 32'd35);

    // Reset mid-operation aborts without a done pulse
    issue(32'd123456, 32'd11, 1'b0);
    wait_cyc(t0 + 9);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_quotient", bus.quotient, 32'd0);
    chk("midreset_done", 32'(bus.done), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd9, 32'd3, 1'b0);

    // Random mix
    for (int i = 0; i < 1500; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'($urandom_range(1, 15));
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : b; end
        3: b = b >> $urandom_range(0, 31);
        4: a = a >> $urandom_range(0, 31);
        5: b = -(32'($urandom_range(1, 100)));
        default: ;
      endcase
      issue(a, b, s);
    end

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
